// File: rtl/branch_jump_detect_pkg.sv
// Shared definitions for branch_jump_detect: branch condition codes and
// the MEM-slot FSM state encoding.
package branch_jump_detect_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RESOLVE = 1'b1
  } bj_state_t;

endpackage

// File: rtl/branch_jump_detect_cmp.sv
// branch_cmp: combinational branch condition evaluator. Reserved funct3
// codes (010/011) evaluate to not-taken.
module branch_cmp
  import branch_jump_detect_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            cond
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  // Select the comparison named by funct3.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = !lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = !lt_u;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_jump_detect.sv
// branch_jump_detect: resolves branches, JAL and JALR in EX and holds the
// outcome in a one-entry MEM slot that drives fetch redirection and flush.
// Optional feature macro: BRANCH_STATS_EN adds saturating resolved/taken
// counters and their two output ports.
//
// state   | meaning
// IDLE    | no control instruction in MEM; EX may latch into the slot
// RESOLVE | slot holds a control instruction; redirect + flush asserted
module branch_jump_detect
  import branch_jump_detect_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            stall,
  output logic            branchjumpdetectout_mem_is_branch_jump,
  output logic            branchjumpdetectout_sel,
  output logic [XLEN-1:0] branchjumpdetectout_pc_addr1,
  output logic [XLEN-1:0] branchjumpdetectout_mem_pc_addr0,
  output logic            branchjumpdetectout_flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     branchjumpdetectout_branch_cnt,
  output logic [31:0]     branchjumpdetectout_taken_cnt
`endif
);

  localparam logic [XLEN-1:0] LSB_CLEAR = ~XLEN'(1);

  bj_state_t       state;
  bj_state_t       state_nx;
  logic            cond;
  logic            ex_ctrl;
  logic            ex_taken;
  logic            kill;
  logic            latch;
  logic [XLEN-1:0] ex_target;
  logic [XLEN-1:0] ex_fall;
  logic            slot_sel;
  logic [XLEN-1:0] slot_target;
  logic [XLEN-1:0] slot_fall;
  logic            is_bj;
  logic            flush;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3 (ex_funct3),
    .rs1    (ex_rs1_data),
    .rs2    (ex_rs2_data),
    .cond   (cond)
  );

  // EX decision: jumps are always taken; JALR target wins over JAL/branch.
  always_comb begin
    ex_ctrl  = ex_is_branch | ex_is_jal | ex_is_jalr;
    ex_taken = ex_is_jalr | ex_is_jal | (ex_is_branch & cond);
    ex_fall  = ex_pc + XLEN'(4);
    if (ex_is_jalr) ex_target = (ex_rs1_data + ex_imm) & LSB_CLEAR;
    else            ex_target = ex_pc + ex_imm;
  end

  // Anything in EX while RESOLVE is active is wrong-path and never latched.
  assign kill  = (state == RESOLVE);
  assign latch = (state == IDLE) & ex_valid & ex_ctrl & !kill & !stall;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (latch) state_nx = RESOLVE;
      RESOLVE: if (!stall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: redirect and flush for every cycle spent in RESOLVE.
  always_comb begin
    is_bj = 1'b0;
    flush = 1'b0;
    if (state == RESOLVE) begin
      is_bj = 1'b1;
      flush = 1'b1;
    end
  end

  // MEM slot: only written on IDLE->RESOLVE, so it is stable through RESOLVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_sel    <= 1'b0;
      slot_target <= '0;
      slot_fall   <= '0;
    end else if (latch) begin
      slot_sel    <= ex_taken;
      slot_target <= ex_target;
      slot_fall   <= ex_fall;
    end
  end

  assign branchjumpdetectout_mem_is_branch_jump = is_bj;
  assign branchjumpdetectout_flush              = flush;
  assign branchjumpdetectout_sel                = slot_sel;
  assign branchjumpdetectout_pc_addr1           = slot_target;
  assign branchjumpdetectout_mem_pc_addr0       = slot_fall;

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] taken_cnt_q;

  // Saturating statistics, counted at the moment an instruction is latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else if (latch) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (ex_taken && taken_cnt_q != 32'hFFFF_FFFF) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign branchjumpdetectout_branch_cnt = branch_cnt_q;
  assign branchjumpdetectout_taken_cnt  = taken_cnt_q;
`endif

endmodule

// File: doc/branch_jump_detect.md
# branch_jump_detect

Resolves conditional branches, JAL and JALR in EX. Registers the outcome into a MEM-stage slot. Drives the PC-select, target, fall-through and flush signals that the next-PC multiplexer and the pipeline registers consume. The datapath is always-flush: every control instruction reaching MEM redirects fetch, either to its target or to its own PC+4.

## Interface
- XLEN, 32, data/address width
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX holds a live instruction
- ex_is_branch  in  1  conditional branch (B-type)
- ex_is_jal  in  1  JAL
- ex_is_jalr  in  1  JALR
- ex_funct3  in  3  branch condition code
- ex_rs1_data  in  XLEN  forwarded rs1
- ex_rs2_data  in  XLEN  forwarded rs2
- ex_pc  in  XLEN  PC of the EX instruction
- ex_imm  in  XLEN  sign-extended immediate
- stall  in  1  MEM stage held this cycle
- branchjumpdetectout_mem_is_branch_jump  out  1  control instruction resolving in MEM; redirect fetch
- branchjumpdetectout_sel  out  1  1 = taken (use target), 0 = not taken (use fall-through)
- branchjumpdetectout_pc_addr1  out  XLEN  taken target
- branchjumpdetectout_mem_pc_addr0  out  XLEN  MEM PC + 4
- branchjumpdetectout_flush  out  1  clear IF/ID, ID/EX and EX/MEM this cycle
- branchjumpdetectout_branch_cnt  out  32  (BRANCH_STATS_EN only) resolved control instructions
- branchjumpdetectout_taken_cnt  out  32  (BRANCH_STATS_EN only) taken control instructions

## Operation
- The EX decision is combinational.
  - taken = jal | jalr | (branch & cond(funct3)).
  - Conditions: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - Funct3 010/011 with ex_is_branch are treated as not-taken control instructions. They still redirect to PC+4.
- Targets, all modulo 2^XLEN:
  - branch/JAL: ex_pc + ex_imm
  - JALR: (ex_rs1_data + ex_imm) & ~1
  - fall-through: ex_pc + 4
- Priority if several type flags are high: jalr > jal > branch.
- FSM states:
  - IDLE: no control instruction in MEM. If ex_valid & (branch|jal|jalr) & !kill & !stall, latch the decision and go to RESOLVE.
  - RESOLVE: is_branch_jump=1, flush=1. If stall, hold all outputs and stay. Otherwise go to IDLE.
- kill: the EX instruction present in the RESOLVE cycle is wrong-path. It is never latched, even if it is a control instruction.
- Back-to-back control instructions therefore cannot both resolve. The younger one is squashed and refetched.
- stall in IDLE: MEM slot unchanged, EX input ignored. The pipeline re-presents it.
- rst has priority over everything, including mid-RESOLVE with stall held.

## Timing
- Latency: EX cycle N → outputs asserted in cycle N+1 (registered).
- is_branch_jump and flush are high exactly 1 cycle per control instruction, plus any stall cycles.
- sel, pc_addr1 and mem_pc_addr0 are stable throughout RESOLVE. Their values in IDLE are don't-care but must not glitch during RESOLVE.
- Reset values: state IDLE; all outputs 0; counters 0.

## Configuration
- BRANCH_STATS_EN defined:
  - branch_cnt increments on each IDLE→RESOLVE transition.
  - taken_cnt increments on the same transition when taken.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: both count ports and their counter logic are absent.

## Structure
- Shared package holds:
  - funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU)
  - the FSM state typedef (IDLE, RESOLVE)
- Sub-module branch_cmp: combinational comparator taking funct3, rs1, rs2 and returning cond.
- Top module holds the target adders, the MEM slot registers, the FSM and the optional counters.

## Test plan
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20 → next cycle is_branch_jump=1, sel=1, pc_addr1=0x120, mem_pc_addr0=0x104, flush=1 for 1 cycle.
- BLT with rs1=0xFFFFFFFF, rs2=1 → sel=1. BLTU with the same operands → sel=0, redirect to pc+4.
- JALR, rs1=0x2003, imm=0x10 → pc_addr1=0x2012 (bit0 cleared), sel=1.
- Back-to-back JAL at 0x40 then BNE at 0x44 → only the JAL resolves; BNE is killed, with a single flush pulse.
- stall held 3 cycles during RESOLVE → is_branch_jump, flush and target held 4 cycles total. rst asserted mid-stall → all outputs 0 next cycle.
- BRANCH_STATS_EN: 10 branches, 4 taken → branch_cnt=10, taken_cnt=4. Preload near max → count saturates at 0xFFFFFFFF.
